// File: rtl/regfile_wb_arbiter.sv
// Purpose: arbitrates the register-file write port between ALU writeback and LSU load return,
//          and tracks loads in flight so decode can stall on a pending register.
// Latency: grant and write data are combinational, so the write lands at the next clk edge.
//          A load issue shows up on id_hazard one cycle later.
// Backpressure: the ALU normally wins. The LSU waits on lsu_wb_ready. With the starve guard,
//               a blocked LSU wins after STARVE_LIMIT cycles and the ALU then sees alu_wb_stall.
//
// Optional feature macro: REGFILE_ARB_STARVE_GUARD_EN enables the starvation guard
// (starve_cnt, hold_q). Without it the ALU always has priority and alu_wb_stall is 0.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   alu_wb_valid/rd/data, alu_wb_stall  ALU writeback source; stall = not taken, retry
//   lsu_wb_valid/rd/data, lsu_wb_ready  load-return source (valid/ready handshake)
//   ld_issue_valid, ld_issue_rd         marks a destination pending when a load issues
//   id_rs1/rs2/rd_index, id_hazard      decode operands and the resulting stall request
//   rf_rd_index, rf_rd_content          register-file write port (index 0 = no write)
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_wb_valid,
  input  logic [4:0]  alu_wb_rd,
  input  logic [31:0] alu_wb_data,
  output logic        alu_wb_stall,
  input  logic        lsu_wb_valid,
  output logic        lsu_wb_ready,
  input  logic [4:0]  lsu_wb_rd,
  input  logic [31:0] lsu_wb_data,
  input  logic        ld_issue_valid,
  input  logic [4:0]  ld_issue_rd,
  input  logic [4:0]  id_rs1_index,
  input  logic [4:0]  id_rs2_index,
  input  logic [4:0]  id_rd_index,
  output logic        id_hazard,
  output logic [4:0]  rf_rd_index,
  output logic [31:0] rf_rd_content
);

  if (STARVE_LIMIT < 2 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("regfile_wb_arbiter: STARVE_LIMIT must be in 2..15");
  end

  logic        alu_req;   // ALU actually wants the port (rd 0 never does)
  logic        lsu_win;   // LSU would be granted, ignoring reset
  logic        lsu_acc;   // LSU transfer accepted this cycle
  logic [31:0] pending_q;
  logic [31:0] pending_d;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        rd_hit;

  assign alu_req = alu_wb_valid && (alu_wb_rd != 5'd0);

`ifdef REGFILE_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       hold_q;

  // While hold_q is set, a waiting load return beats the ALU.
  assign lsu_win      = lsu_wb_valid && (hold_q || !alu_req);
  assign alu_wb_stall = rst_n && alu_req && lsu_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
      hold_q     <= 1'b0;
    end else if (!lsu_wb_valid || lsu_win) begin
      // Nothing waiting, or the wait just ended.
      starve_cnt <= 4'd0;
      hold_q     <= 1'b0;
    end else if (starve_cnt != 4'd15) begin
      starve_cnt <= starve_cnt + 4'd1;
      if ((starve_cnt + 4'd1) == LIMIT) begin
        hold_q <= 1'b1;
      end
    end
  end
`else
  assign lsu_win      = lsu_wb_valid && !alu_req;
  assign alu_wb_stall = 1'b0;
`endif

  // Outputs are forced low while reset is asserted, so nothing is written during reset.
  assign lsu_acc      = rst_n && lsu_win;
  assign lsu_wb_ready = lsu_acc;

  always_comb begin
    rf_rd_index   = 5'd0;
    rf_rd_content = 32'd0;
    if (lsu_acc) begin
      rf_rd_index   = lsu_wb_rd;
      rf_rd_content = lsu_wb_data;
    end else if (rst_n && alu_req) begin
      rf_rd_index   = alu_wb_rd;
      rf_rd_content = alu_wb_data;
    end
  end

  // Load scoreboard. A set and clear of the same index in one cycle leaves it set,
  // because the newly issued load is still outstanding.
  always_comb begin
    set_mask = 32'd0;
    clr_mask = 32'd0;
    if (ld_issue_valid && (ld_issue_rd != 5'd0)) begin
      set_mask[ld_issue_rd] = 1'b1;
    end
    if (lsu_acc) begin
      clr_mask[lsu_wb_rd] = 1'b1;
    end
  end

  assign pending_d = ((pending_q & ~clr_mask) | set_mask) & ~32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 32'd0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // A register being written by the load return this cycle is forwarded by the
  // register file, so it does not need to stall decode.
  assign rs1_hit = (id_rs1_index != 5'd0) && pending_q[id_rs1_index]
                   && !(lsu_acc && (lsu_wb_rd == id_rs1_index));
  assign rs2_hit = (id_rs2_index != 5'd0) && pending_q[id_rs2_index]
                   && !(lsu_acc && (lsu_wb_rd == id_rs2_index));
  assign rd_hit  = (id_rd_index != 5'd0) && pending_q[id_rd_index]
                   && !(lsu_acc && (lsu_wb_rd == id_rd_index));

  assign id_hazard = rst_n && (rs1_hit || rs2_hit || rd_hit);

endmodule
